game_countdown: RTL
===================

# game_countdown

Game-clock stage for the brick-smasher design. It consumes the one-second `tick` of the upstream one-second timer and drives that timer's `en` input. It counts a round's remaining time down from a start value, adds bonus seconds on brick hits, and supports pause/resume. It presents two BCD digits to the score/time display and flags time-up to the game FSM.

## Interface
- `START_SECS`, default 60: seconds loaded at round start, legal 0..99.
- `BONUS_SECS`, default 5: seconds added per `bonus` pulse, legal 0..99.
- `WARN_SECS`, default 10: `warn` is high while count is 1..WARN_SECS.

Ports:
- `clk` in 1: system clock, single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-second tick from upstream timer; level, may stay high while upstream is disabled.
- `start` in 1: one-cycle pulse; (re)load START_SECS and run.
- `pause` in 1: one-cycle pulse; toggles RUN/PAUSED.
- `bonus` in 1: one-cycle pulse; add BONUS_SECS.
- `timer_en` out 1: enable to upstream timer.
- `secs_tens` out 4: BCD tens digit of remaining seconds.
- `secs_ones` out 4: BCD ones digit of remaining seconds.
- `running` out 1: state is RUN.
- `warn` out 1: low-time warning level.
- `time_up` out 1: one-cycle pulse when count reaches 0.
- `expired` out 1: level, state is EXPIRED.

## Operation
- Internal count is 7-bit binary, 0..99. BCD outputs are registered and updated on the same edge as the count.
- States are IDLE, RUN, PAUSED and EXPIRED.
- IDLE: count = START_SECS. `start` loads START_SECS and moves to RUN. `pause` and `bonus` are ignored.
- RUN:
  - `tick` decrements by 1.
  - `bonus` adds BONUS_SECS.
  - If `tick` and `bonus` arrive in the same cycle, next = count + BONUS_SECS − 1.
  - All additions saturate at 99.
  - If next = 0, go to EXPIRED.
  - `pause` goes to PAUSED; a tick or bonus in the same cycle is applied first.
- PAUSED: `tick` is ignored. `bonus` is applied with saturation. `pause` returns to RUN.
- EXPIRED: count holds 0. `pause` and `bonus` are ignored.
- `start` has highest priority in every state: count = START_SECS and the state goes to RUN. If START_SECS = 0, the state goes to EXPIRED with a `time_up` pulse.
- `timer_en` is registered and high exactly while the state is RUN. Pausing therefore freezes the upstream partial second, and it resumes without loss.
- `tick` is qualified by the RUN state only. A tick held high by a disabled upstream timer is consumed on the first RUN cycle after resume, exactly once, because upstream clears when enabled.
- `warn` = (1 ≤ count ≤ WARN_SECS) and state ≠ IDLE.

## Timing
- Reset (async, `reset_n` low) values:
  - state IDLE, count = START_SECS;
  - `timer_en`, `running`, `warn`, `time_up` and `expired` are 0;
  - digits show START_SECS.
- Releasing reset mid-round returns to IDLE; no `time_up` pulse is generated.
- Latency:
  - Input pulse in cycle N → count, digits, state and flags updated at edge N+1.
  - `timer_en` rises at edge N+1 after `start` and falls at edge N+1 after `pause`.
- `time_up`: high for exactly the one cycle following the edge that enters EXPIRED, coincident with `expired` rising. Re-entry via a new `start` can pulse it again.
- Each tick observed in RUN causes exactly one decrement. There is no double count when `tick` is high on consecutive RUN cycles: upstream clears in the cycle the tick is seen.

## Test plan
- Reset, then `start`, then 60 `tick` pulses → digits step 6/0, 5/9, … 0/1, 0/0. `time_up` pulses once on the 60th tick. `expired` = 1, `timer_en` = 0.
- Count 3, `pause`, `tick` held high 20 cycles, then `pause` → no change while paused. The held tick is consumed on resume: count = 2.
- Count 1 with `tick` and `bonus` in the same cycle → count 5 (1 + 5 − 1), no `time_up`, state stays RUN.
- Count 97, `bonus` → 99 (saturate). `bonus` again in PAUSED → stays 99.
- In EXPIRED, `start` → count 60, RUN, `timer_en` high next cycle, `expired` 0. `warn` goes high when the count reaches 10.
- `reset_n` asserted at count 7 in RUN → all outputs go to reset values immediately (asynchronously). After release: IDLE, digits 6/0.

Source files
------------

// File: rtl/game_countdown.sv
// ---------------------------------------------------------------------------
// game_countdown
//
// Game-clock stage for the brick-smasher design. Counts the remaining round
// time down once per upstream one-second tick, adds bonus seconds on brick
// hits, supports pause/resume and flags time-up to the game FSM.
//
// Parameters
//   START_SECS : seconds loaded at round start (0..99)
//   BONUS_SECS : seconds added per bonus pulse (0..99)
//   WARN_SECS  : warn is high while the count is 1..WARN_SECS
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   tick       in   one-second tick (level) from the upstream timer
//   start      in   pulse: (re)load START_SECS and run
//   pause      in   pulse: toggle RUN / PAUSED
//   bonus      in   pulse: add BONUS_SECS
//   timer_en   out  registered enable back to the upstream timer (state RUN)
//   secs_tens  out  BCD tens digit of the remaining seconds (registered)
//   secs_ones  out  BCD ones digit of the remaining seconds (registered)
//   running    out  state is RUN
//   warn       out  low-time warning level
//   time_up    out  one-cycle pulse on the edge entering EXPIRED
//   expired    out  state is EXPIRED
//   state_dbg  out  current FSM state encoding, for observation only
//
// Handshake: there is no valid/ready pair. Every input is a single-cycle
// pulse sampled on the rising edge of clk (tick is a level qualified by the
// RUN state); every output reflects the registered state after that edge.
// ---------------------------------------------------------------------------
module game_countdown #(
   parameter int START_SECS = 60,
   parameter int BONUS_SECS = 5,
   parameter int WARN_SECS  = 10
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick,
   input  logic       start,
   input  logic       pause,
   input  logic       bonus,
   output logic       timer_en,
   output logic [3:0] secs_tens,
   output logic [3:0] secs_ones,
   output logic       running,
   output logic       warn,
   output logic       time_up,
   output logic       expired,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   localparam logic [6:0] START_C = 7'(START_SECS);
   localparam logic [7:0] BONUS_C = 8'(BONUS_SECS);
   localparam logic [6:0] WARN_C  = 7'(WARN_SECS);
   localparam logic [7:0] MAX_C   = 8'd99;

   // Binary 0..99 to two packed BCD digits {tens, ones} (shift-add-3).
   function automatic logic [7:0] to_bcd(input logic [6:0] bin);
      logic [14:0] sh;
      sh = {8'd0, bin};
      for (int i = 0; i < 7; i++) begin
         if (sh[10:7] >= 4'd5) sh[10:7] = sh[10:7] + 4'd3;
         if (sh[14:11] >= 4'd5) sh[14:11] = sh[14:11] + 4'd3;
         sh = sh << 1;
      end
      return sh[14:7];
   endfunction

   localparam logic [7:0] START_BCD = to_bcd(START_C);

   state_t     state_q, state_d;
   logic [6:0] count_q, count_d;
   logic [3:0] tens_q, ones_q;
   logic       timer_en_q;
   logic       time_up_q, time_up_d;
   logic [7:0] bcd_d;
   logic [7:0] run_sum;
   logic [7:0] run_next;
   logic [7:0] pause_sum;
   logic [6:0] pause_next;

   // RUN arithmetic: add the bonus first so a tick at count 1 together with a
   // bonus never underflows, then take the tick, then saturate the net result.
   always_comb begin
      run_sum = {1'b0, count_q} + (bonus ? BONUS_C : 8'd0);
      run_next = run_sum;
      if (tick && (run_sum != 8'd0)) run_next = run_sum - 8'd1;
      if (run_next > MAX_C) run_next = MAX_C;
   end

   // PAUSED arithmetic: bonus only, saturating.
   always_comb begin
      pause_sum = {1'b0, count_q} + (bonus ? BONUS_C : 8'd0);
      pause_next = (pause_sum > MAX_C) ? MAX_C[6:0] : pause_sum[6:0];
   end

   // Next-state / next-count logic.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      time_up_d = 1'b0;

      if (start) begin
         // start wins in every state; a zero-length round expires at once.
         count_d = START_C;
         if (START_C == 7'd0) begin
            state_d   = ST_EXPIRED;
            time_up_d = 1'b1;
         end else begin
            state_d = ST_RUN;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               count_d = START_C;
            end
            ST_RUN: begin
               count_d = run_next[6:0];
               if (run_next == 8'd0) begin
                  // Expiry takes precedence over a coincident pause.
                  state_d   = ST_EXPIRED;
                  time_up_d = 1'b1;
               end else if (pause) begin
                  state_d = ST_PAUSED;
               end
            end
            ST_PAUSED: begin
               // tick is deliberately ignored here: the upstream timer is
               // disabled and its partial second is frozen.
               count_d = pause_next;
               if (pause) state_d = ST_RUN;
            end
            ST_EXPIRED: begin
               count_d = 7'd0;
            end
            default: begin
               state_d = ST_IDLE;
               count_d = START_C;
            end
         endcase
      end
   end

   assign bcd_d = to_bcd(count_d);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         count_q    <= START_C;
         tens_q     <= START_BCD[7:4];
         ones_q     <= START_BCD[3:0];
         timer_en_q <= 1'b0;
         time_up_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         tens_q     <= bcd_d[7:4];
         ones_q     <= bcd_d[3:0];
         // Registered from the next state so it tracks RUN exactly.
         timer_en_q <= (state_d == ST_RUN);
         time_up_q  <= time_up_d;
      end
   end

   assign timer_en  = timer_en_q;
   assign secs_tens = tens_q;
   assign secs_ones = ones_q;
   assign running   = (state_q == ST_RUN);
   assign expired   = (state_q == ST_EXPIRED);
   assign time_up   = time_up_q;
   assign warn      = (state_q != ST_IDLE) && (count_q >= 7'd1) &&
                      (count_q <= WARN_C);
   assign state_dbg = state_q;

endmodule
